// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer. Each entry holds a valid bit, a tag, a
// target and a 2-bit direction counter. The fetch-stage lookup is
// combinational. The decode-stage resolution updates the table, requests a
// flush one cycle after a mispredict, and keeps saturating statistics.
`timescale 1ns/1ps
module branch_target_buffer #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 26,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [31:0]      FetchPC,
  output logic             PredHit,
  output logic             PredTaken,
  output logic [31:0]      PredTarget,
  input  logic             ResValid,
  input  logic [31:0]      ResPC,
  input  logic             ResIsBranch,
  input  logic             ResTaken,
  input  logic [31:0]      ResTarget,
  input  logic             ResPredTaken,
  input  logic [31:0]      ResPredTarget,
  output logic             Flush,
  output logic [31:0]      FlushPC,
  output logic [CNT_W-1:0] CorrectCnt,
  output logic [CNT_W-1:0] MispredCnt
);

  localparam int unsigned ENTRIES = 1 << IDX_W;

  logic [ENTRIES-1:0] vld;
  logic [TAG_W-1:0]   tags [ENTRIES];
  logic [31:0]        tgts [ENTRIES];
  logic [1:0]         ctrs [ENTRIES];

  logic [IDX_W-1:0]   fidx;
  logic [TAG_W-1:0]   ftag;
  logic [IDX_W-1:0]   ridx;
  logic [TAG_W-1:0]   rtag;
  logic               rmatch;
  logic               resbr;
  logic               mispred;
  logic [1:0]         unused_fetch_lsbs;

  // The low two PC bits never take part in indexing or tagging.
  assign unused_fetch_lsbs = FetchPC[1:0];

  assign fidx = FetchPC[IDX_W+1:2];
  assign ftag = FetchPC[31:IDX_W+2];
  assign ridx = ResPC[IDX_W+1:2];
  assign rtag = ResPC[31:IDX_W+2];

  // Fetch lookup reads registered table state only, so an update in the same
  // cycle becomes visible from the next cycle.
  always_comb begin
    PredHit    = vld[fidx] && (tags[fidx] == ftag);
    PredTaken  = PredHit && ctrs[fidx][1];
    PredTarget = PredHit ? tgts[fidx] : '0;
  end

  // Resolution classification: match against the stored entry and mispredict detection.
  always_comb begin
    rmatch  = vld[ridx] && (tags[ridx] == rtag);
    resbr   = ResValid && ResIsBranch;
    mispred = resbr && ((ResPredTaken != ResTaken) ||
                        (ResPredTaken && ResTaken && (ResPredTarget != ResTarget)));
  end

  // Table update: train on matching branches, allocate on taken misses,
  // and drop entries that turn out to alias a non-branch.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      vld <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tags[i] <= '0;
        tgts[i] <= '0;
        ctrs[i] <= 2'b01;
      end
    end else if (ResValid) begin
      if (ResIsBranch) begin
        if (rmatch) begin
          if (ResTaken) begin
            if (ctrs[ridx] != 2'b11) ctrs[ridx] <= ctrs[ridx] + 2'd1;
            tgts[ridx] <= ResTarget;
          end else if (ctrs[ridx] != 2'b00) begin
            ctrs[ridx] <= ctrs[ridx] - 2'd1;
          end
        end else if (ResTaken) begin
          vld[ridx]  <= 1'b1;
          tags[ridx] <= rtag;
          tgts[ridx] <= ResTarget;
          ctrs[ridx] <= 2'b10;
        end
      end else if (rmatch) begin
        vld[ridx] <= 1'b0;
      end
    end
  end

  // One-cycle flush request carrying the corrected fetch PC.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Flush   <= 1'b0;
      FlushPC <= '0;
    end else begin
      Flush <= mispred;
      if (mispred) FlushPC <= ResTaken ? ResTarget : ResPC + 32'd4;
    end
  end

  // Saturating statistics of correct and mispredicted branch resolutions.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      CorrectCnt <= '0;
      MispredCnt <= '0;
    end else if (resbr) begin
      if (mispred) begin
        if (MispredCnt != '1) MispredCnt <= MispredCnt + CNT_W'(1);
      end else begin
        if (CorrectCnt != '1) CorrectCnt <= CorrectCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios plus a
// randomized run against a behavioural table model.
`timescale 1ns/1ps
module tb_branch_target_buffer;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] FetchPC;
  logic        PredHit, PredTaken;
  logic [31:0] PredTarget;
  logic        ResValid, ResIsBranch, ResTaken, ResPredTaken;
  logic [31:0] ResPC, ResTarget, ResPredTarget;
  logic        Flush;
  logic [31:0] FlushPC;
  logic [15:0] CorrectCnt, MispredCnt;

  branch_target_buffer #(.IDX_W(4), .TAG_W(26), .CNT_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .FetchPC(FetchPC),
    .PredHit(PredHit), .PredTaken(PredTaken), .PredTarget(PredTarget),
    .ResValid(ResValid), .ResPC(ResPC), .ResIsBranch(ResIsBranch),
    .ResTaken(ResTaken), .ResTarget(ResTarget), .ResPredTaken(ResPredTaken),
    .ResPredTarget(ResPredTarget), .Flush(Flush), .FlushPC(FlushPC),
    .CorrectCnt(CorrectCnt), .MispredCnt(MispredCnt)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: 16 slots chosen by (pc/4) mod 16, tag = pc/64.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  bit          exp_flush;
  logic [31:0] exp_fpc;
  int          exp_corr, exp_misp;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic void look(input logic [31:0] pc, output bit h, output bit t,
                               output logic [31:0] tg);
    int s = slot(pc);
    h  = m_valid[s] && (m_tag[s] == pc / 64);
    t  = h && (m_ctr[s] >= 2);
    tg = h ? m_tgt[s] : 32'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    exp_flush = 0; exp_fpc = 0; exp_corr = 0; exp_misp = 0;
  endtask

  task automatic model_resolve(input logic [31:0] pc, input bit isb, input bit tk,
                               input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    int s = slot(pc);
    bit hit = m_valid[s] && (m_tag[s] == pc / 64);
    bit mis;
    exp_flush = 0;
    if (!isb) begin
      if (hit) m_valid[s] = 0;
      return;
    end
    mis = (ptk != tk) || (ptk && tk && ptgt != tgt);
    if (mis) begin
      exp_flush = 1;
      exp_fpc   = tk ? tgt : pc + 32'd4;
      if (exp_misp < 65535) exp_misp++;
    end else if (exp_corr < 65535) begin
      exp_corr++;
    end
    if (hit) begin
      if (tk) begin
        if (m_ctr[s] < 3) m_ctr[s]++;
        m_tgt[s] = tgt;
      end else if (m_ctr[s] > 0) begin
        m_ctr[s]--;
      end
    end else if (tk) begin
      m_valid[s] = 1; m_tag[s] = pc / 64; m_tgt[s] = tgt; m_ctr[s] = 2;
    end
  endtask

  // Drives one resolution for one clock edge and advances the model.
  task automatic apply(input logic [31:0] pc, input bit isb, input bit tk,
                       input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    @(negedge Clk);
    ResValid = 1; ResPC = pc; ResIsBranch = isb; ResTaken = tk;
    ResTarget = tgt; ResPredTaken = ptk; ResPredTarget = ptgt;
    @(posedge Clk);
    model_resolve(pc, isb, tk, tgt, ptk, ptgt);
    #1 ResValid = 0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1; ResValid = 0;
    @(posedge Clk);
    model_reset();
    #1 Rst = 0;
  endtask

  task automatic test_reset();
    FetchPC = 32'h40;
    do_reset();
    #1;
    checks++; if (PredHit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b expected 0", PredHit); end
    checks++; if (PredTaken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %b expected 0", PredTaken); end
    checks++; if (PredTarget !== 32'h0) begin errors++; $display("FAIL reset_target: got %h expected 0", PredTarget); end
    checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b expected 0", Flush); end
    checks++; if (CorrectCnt !== 16'h0 || MispredCnt !== 16'h0)
      begin errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", CorrectCnt, MispredCnt); end
  endtask

  task automatic test_allocate();
    apply(32'h40, 1, 1, 32'h100, 0, 32'h0);
    checks++; if (Flush !== 1'b1 || FlushPC !== 32'h100)
      begin errors++; $display("FAIL alloc_flush: got %b/%h expected 1/00000100", Flush, FlushPC); end
    checks++; if (MispredCnt !== 16'd1) begin errors++; $display("FAIL alloc_mispcnt: got %0d expected 1", MispredCnt); end
    FetchPC = 32'h40; #1;
    checks++; if ({PredHit, PredTaken} !== 2'b11 || PredTarget !== 32'h100)
      begin errors++; $display("FAIL alloc_lookup: got %b%b/%h expected 11/00000100", PredHit, PredTaken, PredTarget); end
    @(posedge Clk); #1;
    checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL alloc_flush_drop: got %b expected 0", Flush); end
  endtask

  task automatic test_saturation();
    bit exp_t [3] = '{1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 3; k++) apply(32'h40, 1, 1, 32'h100, 1, 32'h100);
    checks++; if (CorrectCnt !== 16'd3) begin errors++; $display("FAIL sat_correct: got %0d expected 3", CorrectCnt); end
    checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL sat_noflush: got %b expected 0", Flush); end
    // Three back-to-back not-taken mispredicts: each must flush in its own cycle.
    for (int k = 0; k < 3; k++) begin
      apply(32'h40, 1, 0, 32'h0, 1, 32'h100);
      checks++; if (Flush !== 1'b1 || FlushPC !== 32'h44)
        begin errors++; $display("FAIL b2b_flush%0d: got %b/%h expected 1/00000044", k, Flush, FlushPC); end
      FetchPC = 32'h40; #1;
      checks++; if (PredHit !== 1'b1 || PredTaken !== exp_t[k])
        begin errors++; $display("FAIL sat_pred%0d: got %b%b expected 1%b", k, PredHit, PredTaken, exp_t[k]); end
    end
    checks++; if (MispredCnt !== 16'd4) begin errors++; $display("FAIL sat_mispcnt: got %0d expected 4", MispredCnt); end
  endtask

  task automatic test_alias();
    apply(32'h440, 1, 1, 32'h200, 0, 32'h0);
    FetchPC = 32'h40; #1;
    checks++; if (PredHit !== 1'b0) begin errors++; $display("FAIL alias_old: got %b expected 0", PredHit); end
    FetchPC = 32'h440; #1;
    checks++; if (PredHit !== 1'b1 || PredTarget !== 32'h200)
      begin errors++; $display("FAIL alias_new: got %b/%h expected 1/00000200", PredHit, PredTarget); end
    apply(32'h440, 0, 0, 32'h0, 0, 32'h0);
    #1;
    checks++; if (PredHit !== 1'b0) begin errors++; $display("FAIL alias_inval: got %b expected 0", PredHit); end
    checks++; if (Flush !== 1'b0 || MispredCnt !== 16'd5 || CorrectCnt !== 16'd3)
      begin errors++; $display("FAIL alias_nonbr_stats: got %b %0d/%0d expected 0 3/5", Flush, CorrectCnt, MispredCnt); end
  endtask

  task automatic test_same_cycle();
    @(negedge Clk);
    FetchPC = 32'h80;
    ResValid = 1; ResPC = 32'h80; ResIsBranch = 1; ResTaken = 1;
    ResTarget = 32'h300; ResPredTaken = 0; ResPredTarget = 0;
    #1;
    checks++; if (PredHit !== 1'b0) begin errors++; $display("FAIL same_pre: got %b expected 0", PredHit); end
    @(posedge Clk);
    model_resolve(32'h80, 1, 1, 32'h300, 0, 32'h0);
    #1 ResValid = 0;
    checks++; if (PredHit !== 1'b1 || PredTarget !== 32'h300)
      begin errors++; $display("FAIL same_post: got %b/%h expected 1/00000300", PredHit, PredTarget); end
    // Reset must win over a simultaneous mispredicting resolve.
    @(negedge Clk);
    Rst = 1; ResValid = 1; ResPC = 32'h80; ResIsBranch = 1; ResTaken = 0; ResPredTaken = 1;
    @(posedge Clk);
    model_reset();
    #1 Rst = 0; ResValid = 0;
    checks++; if (Flush !== 1'b0 || CorrectCnt !== 16'd0 || MispredCnt !== 16'd0)
      begin errors++; $display("FAIL rst_override: got %b %0d/%0d expected 0 0/0", Flush, CorrectCnt, MispredCnt); end
    FetchPC = 32'h80; #1;
    checks++; if (PredHit !== 1'b0) begin errors++; $display("FAIL rst_table: got %b expected 0", PredHit); end
  endtask

  task automatic test_random();
    logic [31:0] pool [6] = '{32'h40, 32'h440, 32'h80, 32'h1080, 32'hC4, 32'h8C};
    logic [31:0] pc, tgt, ptgt, mtg;
    bit tk, isb, ptk, mh, mt;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      FetchPC = pool[$urandom_range(5)] | 32'($urandom_range(3));
      #1;
      look(FetchPC, mh, mt, mtg);
      checks++; if ({PredHit, PredTaken, PredTarget} !== {mh, mt, mtg})
        begin errors++; $display("FAIL rnd_lookup: pc %h got %b%b/%h expected %b%b/%h",
                                 FetchPC, PredHit, PredTaken, PredTarget, mh, mt, mtg); end
      pc   = pool[$urandom_range(5)] | 32'($urandom_range(3));
      isb  = ($urandom_range(7) != 0);
      tk   = $urandom_range(1) == 1;
      tgt  = ($urandom_range(1) == 1) ? 32'h100 : {$urandom, 2'b00} ;
      look(pc, mh, mt, mtg);
      ptk  = ($urandom_range(3) != 0) ? mt : ($urandom_range(1) == 1);
      ptgt = ($urandom_range(3) != 0) ? mtg : 32'h100;
      apply(pc, isb, tk, tgt, ptk, ptgt);
      checks++; if (Flush !== exp_flush || (exp_flush && FlushPC !== exp_fpc))
        begin errors++; $display("FAIL rnd_flush: got %b/%h expected %b/%h", Flush, FlushPC, exp_flush, exp_fpc); end
      checks++; if (CorrectCnt !== 16'(exp_corr) || MispredCnt !== 16'(exp_misp))
        begin errors++; $display("FAIL rnd_counts: got %0d/%0d expected %0d/%0d",
                                 CorrectCnt, MispredCnt, exp_corr, exp_misp); end
    end
  endtask

  task automatic test_counter_saturation();
    do_reset();
    @(negedge Clk);
    ResValid = 1; ResPC = 32'h40; ResIsBranch = 1; ResTaken = 0;
    ResTarget = 0; ResPredTaken = 0; ResPredTarget = 0;
    for (int n = 0; n < 65535; n++) begin
      @(posedge Clk);
      model_resolve(32'h40, 1, 0, 32'h0, 0, 32'h0);
    end
    #1 ResValid = 0;
    checks++; if (CorrectCnt !== 16'(exp_corr))
      begin errors++; $display("FAIL cnt_fill: got %h expected %h", CorrectCnt, 16'(exp_corr)); end
    apply(32'h40, 1, 0, 32'h0, 0, 32'h0);
    checks++; if (CorrectCnt !== 16'hFFFF || 16'(exp_corr) !== CorrectCnt)
      begin errors++; $display("FAIL cnt_saturate: got %h expected ffff", CorrectCnt); end
    checks++; if (MispredCnt !== 16'(exp_misp))
      begin errors++; $display("FAIL cnt_misp_steady: got %0d expected %0d", MispredCnt, exp_misp); end
  endtask

  initial begin
    Rst = 0; FetchPC = 0; ResValid = 0; ResPC = 0; ResIsBranch = 0; ResTaken = 0;
    ResTarget = 0; ResPredTaken = 0; ResPredTarget = 0;
    model_reset();
    test_reset();
    test_allocate();
    test_saturation();
    test_alias();
    test_same_cycle();
    test_random();
    test_counter_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
